alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage.sv | 100 ++++++++++
 tb/tb_alu_operand_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ALU operand stage: decodes a 16-bit instruction, checks the busy scoreboard,
// reads operands from an 8x16 register file and issues to the ALU.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_instr upstream;
// out_valid/out_ready/alu_a/alu_b/alu_op/alu_rd downstream; wb_en/wb_addr/
// wb_data writeback; illegal_op pulses when an op-2 word is dropped.
// Option: define ALU_OPERAND_BYPASS_EN for same-cycle writeback bypass.
module alu_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_rd,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        illegal_op
);

  logic [15:0] rf [8];
  logic [7:0]  busy;

  logic [2:0]  op, rd, rs, rt;
  logic        legal;
  logic        wb_hit;
  logic        byp_s, byp_t;
  logic [15:0] opa, opb;
  logic        hazard;
  logic        accept;
  logic [7:0]  clr, set;

  assign op = in_instr[15:13];
  assign rd = in_instr[12:10];
  assign rs = in_instr[9:7];
  assign rt = in_instr[6:4];

  assign legal  = (op != 3'd2);
  assign wb_hit = wb_en && (wb_addr != 3'd0);

`ifdef ALU_OPERAND_BYPASS_EN
  assign byp_s = wb_hit && (wb_addr == rs);
  assign byp_t = wb_hit && (wb_addr == rt);
  assign opa   = byp_s ? wb_data : rf[rs];
  assign opb   = byp_t ? wb_data : rf[rt];
`else
  assign byp_s = 1'b0;
  assign byp_t = 1'b0;
  assign opa   = rf[rs];
  assign opb   = rf[rt];
`endif

  // A forwarded writeback satisfies a source dependency; rd still waits.
  assign hazard = legal &&
                  ((busy[rs] && !byp_s) ||
                   (busy[rt] && !byp_t) ||
                   busy[rd]);

  // Illegal words are always swallowed so they never stall the stream.
  assign in_ready = !reset &&
                    (!legal ||
                     ((!out_valid || out_ready) && !hazard));

  assign accept = in_valid && in_ready && legal;

  assign clr = wb_hit ? (8'd1 << wb_addr) : 8'd0;
  assign set = (accept && rd != 3'd0) ? (8'd1 << rd) : 8'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      busy       <= '0;
      out_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_rd     <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (wb_hit) rf[wb_addr] <= wb_data;
      // Set after clear: a new issue to rd outranks its old writeback.
      busy <= (busy & ~clr) | set;
      if (accept) begin
        out_valid <= 1'b1;
        alu_a     <= opa;
        alu_b     <= opb;
        alu_op    <= op;
        alu_rd    <= rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      illegal_op <= in_valid && !legal;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table plus randomized
// traffic against a behavioural register-file/scoreboard model.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready;
  logic [15:0] in_instr;
  logic        out_valid, out_ready;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op, alu_rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal_op;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rd(alu_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal_op(illegal_op)
  );

  typedef struct {
    logic        rst, iv;
    logic [15:0] ins;
    logic        ordy, we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        e_rdy, e_ov;
    logic [15:0] e_a, e_b;
    logic [2:0]  e_op, e_rd;
    logic        e_ill;
  } vec_t;

  vec_t tv[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic rst, iv, input logic [15:0] ins,
                      input logic ordy, we, input logic [2:0] wa,
                      input logic [15:0] wd, input logic e_rdy, e_ov,
                      input logic [15:0] e_a, e_b,
                      input logic [2:0] e_op, e_rd, input logic e_ill);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ins = ins; v.ordy = ordy;
    v.we = we; v.wa = wa; v.wd = wd;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_a = e_a; v.e_b = e_b;
    v.e_op = e_op; v.e_rd = e_rd; v.e_ill = e_ill;
    tv.push_back(v);
  endtask

  task automatic drive(input logic rst, iv, input logic [15:0] ins,
                       input logic ordy, we, input logic [2:0] wa,
                       input logic [15:0] wd);
    @(negedge clk);
    reset = rst; in_valid = iv; in_instr = ins;
    out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic chk_out(input string p, input logic ov,
                         input logic [15:0] a, b,
                         input logic [2:0] op, rd, input logic ill);
    chk({p, " out_valid"}, out_valid, ov);
    chk({p, " alu_a"}, alu_a, a);
    chk({p, " alu_b"}, alu_b, b);
    chk({p, " alu_op"}, alu_op, op);
    chk({p, " alu_rd"}, alu_rd, rd);
    chk({p, " illegal_op"}, illegal_op, ill);
  endtask

  // behavioural model state
  logic [15:0] m_rf [8];
  bit   [7:0]  m_busy;
  logic        m_ov, m_ill;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_op, m_rd;

  function automatic bit src_busy(input logic [2:0] x, input logic we,
                                  input logic [2:0] wa);
    return m_busy[x] && !(BYP && we && wa == x && x != 0);
  endfunction

  function automatic logic [15:0] src_val(input logic [2:0] x,
                                          input logic we,
                                          input logic [2:0] wa,
                                          input logic [15:0] wd);
    if (BYP && we && wa == x && x != 0) return wd;
    return m_rf[x];
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0;
    out_ready = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    // add r3,r1,r2=0CA0 sub r4,r3,r1=3190 xor r0=6000
    // add r5/r6 <- r1,r2 = 14A0/18A0
    addv(1,1,16'h0CA0,0,1,3'd7,16'h1234, 0,0,0,0,0,0,0);
    addv(0,0,16'h0000,0,1,3'd1,16'h0005, 1,0,0,0,0,0,0);
    addv(0,0,16'h0000,0,1,3'd2,16'h0003, 1,0,0,0,0,0,0);
    addv(0,1,16'h0CA0,0,0,3'd0,16'h0000, 1,1,5,3,0,3,0);
    addv(0,1,16'h3190,0,0,3'd0,16'h0000, 0,1,5,3,0,3,0);
    addv(0,1,16'h3190,1,0,3'd0,16'h0000, 0,0,5,3,0,3,0);
`ifdef ALU_OPERAND_BYPASS_EN
    addv(0,1,16'h3190,1,1,3'd3,16'h0008, 1,1,8,5,1,4,0);
    addv(0,0,16'h0000,0,0,3'd0,16'h0000, 0,1,8,5,1,4,0);
`else
    addv(0,1,16'h3190,1,1,3'd3,16'h0008, 0,0,5,3,0,3,0);
    addv(0,1,16'h3190,0,0,3'd0,16'h0000, 1,1,8,5,1,4,0);
`endif
    addv(0,1,16'h4000,0,0,3'd0,16'h0000, 1,1,8,5,1,4,1);
    addv(0,0,16'h0000,0,0,3'd0,16'h0000, 0,1,8,5,1,4,0);
    addv(0,0,16'h0000,1,1,3'd4,16'h000D, 1,0,8,5,1,4,0);
    addv(0,1,16'h6000,1,0,3'd0,16'h0000, 1,1,0,0,3,0,0);
    addv(0,0,16'h0000,1,1,3'd0,16'hFFFF, 1,0,0,0,3,0,0);
    addv(0,1,16'h0070,0,0,3'd0,16'h0000, 1,1,0,0,0,0,0);
    addv(0,1,16'h14A0,1,0,3'd0,16'h0000, 1,1,5,3,0,5,0);
    addv(0,1,16'h18A0,1,0,3'd0,16'h0000, 1,1,5,3,0,6,0);
    addv(0,1,16'h0CA0,1,0,3'd0,16'h0000, 1,1,5,3,0,3,0);
    addv(1,1,16'h0CA0,0,1,3'd1,16'h7777, 0,0,0,0,0,0,0);
    addv(0,1,16'h0CA0,0,0,3'd0,16'h0000, 1,1,0,0,0,3,0);
    addv(0,1,16'h14A0,1,0,3'd0,16'h0000, 1,1,0,0,0,5,0);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].iv, tv[i].ins, tv[i].ordy,
            tv[i].we, tv[i].wa, tv[i].wd);
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, tv[i].e_rdy);
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), tv[i].e_ov, tv[i].e_a, tv[i].e_b,
              tv[i].e_op, tv[i].e_rd, tv[i].e_ill);
    end

    for (int c = 0; c < 1500; c++) begin
      logic        rst, iv, ordy, we, legal, e_rdy, acc, hz;
      logic [15:0] ins, wd, va, vb;
      logic [2:0]  wa, op, rd, rs, rt;
      rst  = (c == 0) || ($urandom_range(0, 99) == 0);
      iv   = $urandom_range(0, 3) != 0;
      ins  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ins[15:13] = 3'd2;
      ordy = $urandom_range(0, 9) < 6;
      we   = $urandom_range(0, 9) < 4;
      wa   = 3'($urandom_range(0, 7));
      wd   = 16'($urandom);
      op = ins[15:13]; rd = ins[12:10];
      rs = ins[9:7];   rt = ins[6:4];
      legal = (op != 3'd2);
      hz = src_busy(rs, we, wa) || src_busy(rt, we, wa) || m_busy[rd];
      if (rst)        e_rdy = 1'b0;
      else if (!legal) e_rdy = 1'b1;
      else            e_rdy = (!m_ov || ordy) && !hz;
      va = src_val(rs, we, wa, wd);
      vb = src_val(rt, we, wa, wd);

      drive(rst, iv, ins, ordy, we, wa, wd);
      #1;
      chk($sformatf("r%0d in_ready", c), in_ready, e_rdy);
      @(posedge clk);

      if (rst) begin
        for (int k = 0; k < 8; k++) m_rf[k] = '0;
        m_busy = '0; m_ov = 0; m_ill = 0;
        m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
      end else begin
        acc = iv && e_rdy && legal;
        if (we && wa != 0) begin
          m_rf[wa]   = wd;
          m_busy[wa] = 1'b0;
        end
        if (acc) begin
          m_ov = 1; m_a = va; m_b = vb; m_op = op; m_rd = rd;
          if (rd != 0) m_busy[rd] = 1'b1;
        end else if (ordy) begin
          m_ov = 0;
        end
        m_ill = iv && !legal;
      end

      #1;
      chk_out($sformatf("r%0d", c), m_ov, m_a, m_b, m_op, m_rd, m_ill);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
